// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the default-slave state type used by the
// interconnect and its default slave.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_OKAY = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_t;

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave for unmapped transfers: answers OKAY when idle and gives the
// two-cycle ERROR response (wait + error, then ready + error) when started.
module ahb_default_slave (
  input  logic HCLK,
  input  logic HRESET,
  input  logic HREADY,
  input  logic start,
  output logic ready,
  output logic resp,
  output logic err_inc
);
  import ahb_pkg::*;

  ds_state_t state_q, state_d;
  logic      ready_q, ready_d;
  logic      resp_q, resp_d;

  always_comb begin
    state_d = state_q;
    if (state_q == DS_ERR1) begin
      state_d = DS_ERR2;
    end else if (HREADY) begin
      state_d = start ? DS_ERR1 : DS_OKAY;
    end
    ready_d = (state_d != DS_ERR1);
    resp_d  = (state_d != DS_OKAY) ? HRESP_ERROR : HRESP_OKAY;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= DS_OKAY;
      ready_q <= 1'b1;
      resp_q  <= HRESP_OKAY;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      resp_q  <= resp_d;
    end
  end

  // ERR1 is always left after one cycle, so being headed there marks an entry.
  assign err_inc = (state_d == DS_ERR1);
  assign ready   = ready_q;
  assign resp    = resp_q;

endmodule

// File: rtl/ahb_lite_interconnect.sv
// Single-master AHB-Lite interconnect: priority address decode, registered
// data-phase select, response mux and a saturating default-slave error count.
module ahb_lite_interconnect #(
  parameter int                         N_SLAVES = 3,
  parameter int                         ADDR_W   = 32,
  parameter int                         DATA_W   = 32,
  parameter logic [N_SLAVES*ADDR_W-1:0] SLV_BASE = '0,
  parameter logic [N_SLAVES*ADDR_W-1:0] SLV_MASK = '0,
  parameter int                         ERRCNT_W = 16
) (
  input  logic                         HCLK,
  input  logic                         HRESET,
  input  logic [ADDR_W-1:0]            HADDR,
  input  logic [1:0]                   HTRANS,
  output logic [N_SLAVES-1:0]          HSEL,
  input  logic [N_SLAVES*DATA_W-1:0]   HRDATA_I,
  input  logic [N_SLAVES-1:0]          HRESP_I,
  input  logic [N_SLAVES-1:0]          HREADYOUT_I,
  output logic [DATA_W-1:0]            HRDATA,
  output logic                         HRESP,
  output logic                         HREADY,
  output logic [ERRCNT_W-1:0]          ERR_CNT
);
  import ahb_pkg::*;

  localparam int                DSEL_W   = $clog2(N_SLAVES + 1);
  localparam logic [DSEL_W-1:0] DSEL_DEF = DSEL_W'(N_SLAVES);

  logic [N_SLAVES-1:0] hsel;
  logic [DSEL_W-1:0]   hit_idx;
  logic                any_hit;
  logic [DSEL_W-1:0]   dsel_q, dsel_d;
  logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                ds_ready, ds_resp, ds_inc, ds_start;

  // Lowest index wins when several maps overlap.
  always_comb begin
    hsel    = '0;
    hit_idx = DSEL_DEF;
    any_hit = 1'b0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (!any_hit &&
          ((HADDR & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W])) begin
        hsel[i] = 1'b1;
        hit_idx = DSEL_W'(i);
        any_hit = 1'b1;
      end
    end
  end

  assign HSEL     = hsel;
  assign ds_start = !any_hit && HTRANS[1];

  ahb_default_slave u_default_slave (
    .HCLK    (HCLK),
    .HRESET  (HRESET),
    .HREADY  (HREADY),
    .start   (ds_start),
    .ready   (ds_ready),
    .resp    (ds_resp),
    .err_inc (ds_inc)
  );

  always_comb begin
    HRDATA = '0;
    HRESP  = ds_resp;
    HREADY = ds_ready;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (dsel_q == DSEL_W'(i)) begin
        HRDATA = HRDATA_I[i*DATA_W +: DATA_W];
        HRESP  = HRESP_I[i];
        HREADY = HREADYOUT_I[i];
      end
    end
  end

  always_comb begin
    dsel_d    = HREADY ? hit_idx : dsel_q;
    err_cnt_d = err_cnt_q;
    if (ds_inc && (err_cnt_q != {ERRCNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + ERRCNT_W'(1);
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dsel_q    <= DSEL_DEF;
      err_cnt_q <= '0;
    end else begin
      dsel_q    <= dsel_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign ERR_CNT = err_cnt_q;

endmodule

// File: tb/tb_ahb_lite_interconnect.sv
// Scoreboard bench for ahb_lite_interconnect: directed transfers push expected
// data-phase results; a monitor compares them as each data phase completes.
module tb_ahb_lite_interconnect;
  import ahb_pkg::*;

  localparam int N = 3;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic [2:0]    HSEL;
  logic [95:0]   HRDATA_I;
  logic [2:0]    HRESP_I;
  logic [2:0]    HREADYOUT_I;
  logic [31:0]   HRDATA;
  logic          HRESP;
  logic          HREADY;
  logic [15:0]   ERR_CNT;

  logic [31:0]   HADDR2;
  logic [1:0]    HTRANS2;
  logic [2:0]    HSEL2;
  logic [31:0]   HRDATA2;
  logic          HRESP2;
  logic          HREADY2;
  logic [1:0]    ERR_CNT2;

  logic [31:0]   rdata_cfg [N];
  int            stall_cfg [N];
  logic          resp_cfg  [N];
  int            bench_tgt;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        resp;
    int          waits;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 HCLK = ~HCLK;

  assign HRDATA_I = {rdata_cfg[2], rdata_cfg[1], rdata_cfg[0]};

  ahb_lite_interconnect #(
    .N_SLAVES (3), .ADDR_W (32), .DATA_W (32),
    .SLV_BASE ({32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
    .SLV_MASK ({32'hF000_0000, 32'hF000_0000, 32'hF000_0000}),
    .ERRCNT_W (16)
  ) dut (
    .HCLK (HCLK), .HRESET (HRESET), .HADDR (HADDR), .HTRANS (HTRANS),
    .HSEL (HSEL), .HRDATA_I (HRDATA_I), .HRESP_I (HRESP_I),
    .HREADYOUT_I (HREADYOUT_I), .HRDATA (HRDATA), .HRESP (HRESP),
    .HREADY (HREADY), .ERR_CNT (ERR_CNT)
  );

  // Overlapping map (slaves 0 and 2 both hit 0x4xxx_xxxx) and a tiny counter.
  ahb_lite_interconnect #(
    .N_SLAVES (3), .ADDR_W (32), .DATA_W (32),
    .SLV_BASE ({32'h4000_0000, 32'h1000_0000, 32'h4000_0000}),
    .SLV_MASK ({32'hC000_0000, 32'hF000_0000, 32'hF000_0000}),
    .ERRCNT_W (2)
  ) dut_sat (
    .HCLK (HCLK), .HRESET (HRESET), .HADDR (HADDR2), .HTRANS (HTRANS2),
    .HSEL (HSEL2), .HRDATA_I (96'h0), .HRESP_I (3'b000),
    .HREADYOUT_I (3'b111), .HRDATA (HRDATA2), .HRESP (HRESP2),
    .HREADY (HREADY2), .ERR_CNT (ERR_CNT2)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Behavioural slaves: the slave addressed in an accepted address phase
  // inserts stall_cfg wait states, then answers with resp_cfg.
  initial begin
    int   cur, cnt, t, st;
    logic acc;
    cur = N; cnt = 0;
    HREADYOUT_I = '1;
    HRESP_I     = '0;
    forever begin
      @(negedge HCLK);
      acc = HREADY;
      t   = bench_tgt;
      st  = (t < N) ? stall_cfg[t] : 0;
      @(posedge HCLK);
      #2;
      if (HRESET) begin
        cur = N; cnt = 0;
      end else if (acc) begin
        cur = t; cnt = st;
      end
      HREADYOUT_I = '1;
      HRESP_I     = '0;
      if (cur < N) begin
        if (cnt > 0) begin
          HREADYOUT_I[cur] = 1'b0;
          cnt--;
        end else begin
          HRESP_I[cur] = resp_cfg[cur];
        end
      end
    end
  end

  // Monitor: checks the current data phase every cycle, pops on HREADY.
  initial begin
    int w;
    w = 0;
    forever begin
      @(negedge HCLK);
      if (HRESET) begin
        w = 0;
      end else if (q.size() > 0) begin
        if (!HREADY) begin
          w++;
          chk($sformatf("%s wait_rdata", q[0].tag), HRDATA, q[0].rdata);
          chk($sformatf("%s wait_resp", q[0].tag), 32'(HRESP), 32'(q[0].resp));
        end else begin
          chk($sformatf("%s rdata", q[0].tag), HRDATA, q[0].rdata);
          chk($sformatf("%s resp", q[0].tag), 32'(HRESP), 32'(q[0].resp));
          chk($sformatf("%s waits", q[0].tag), 32'(w), 32'(q[0].waits));
          chk($sformatf("%s err_cnt", q[0].tag), 32'(ERR_CNT), 32'(q[0].cnt));
          void'(q.pop_front());
          w = 0;
        end
      end
    end
  end

  task automatic issue(string tag, logic [31:0] a, logic [1:0] tr, int tgt, bit push,
                       logic [31:0] er, logic rs, int wt, logic [15:0] ct);
    bit acc;
    int b;
    acc = 1'b0; b = 0;
    HADDR = a; HTRANS = tr; bench_tgt = tgt;
    while (!acc && b < 20) begin
      @(negedge HCLK);
      acc = HREADY;
      @(posedge HCLK);
      b++;
    end
    if (!acc) begin
      n_vec++; n_miss++;
      $display("FAIL %s accept: HREADY never 1 within 20 cycles, want 1", tag);
    end else if (push) begin
      q.push_back('{tag: tag, rdata: er, resp: rs, waits: wt, cnt: ct});
    end
    #1;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (q.size() > 0 && b < 50) begin
      @(posedge HCLK);
      b++;
    end
    if (q.size() > 0) begin
      n_vec++; n_miss++;
      $display("FAIL drain: %0d data phases outstanding, want 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    int k, b;
    HRESET = 1'b1;
    HADDR = 32'h2000_0000; HTRANS = HTRANS_IDLE;
    HADDR2 = 32'h0; HTRANS2 = HTRANS_IDLE;
    bench_tgt = N;
    rdata_cfg[0] = 32'h1111_0000; rdata_cfg[1] = 32'hCAFE_F00D; rdata_cfg[2] = 32'h2222_0002;
    for (int i = 0; i < N; i++) begin
      stall_cfg[i] = 0;
      resp_cfg[i]  = 1'b0;
    end

    repeat (2) @(posedge HCLK);
    #1;
    chk("reset HREADY", 32'(HREADY), 32'd1);
    chk("reset HRESP", 32'(HRESP), 32'd0);
    chk("reset HRDATA", HRDATA, 32'h0);
    chk("reset ERR_CNT", 32'(ERR_CNT), 32'd0);
    chk("reset HSEL", 32'(HSEL), 32'b100);
    HRESET = 1'b0;
    @(posedge HCLK);
    #1;

    HADDR = 32'h1000_0040;
    #1;
    chk("decode HSEL s1", 32'(HSEL), 32'b010);
    issue("s1 read", 32'h1000_0040, HTRANS_NONSEQ, 1, 1, 32'hCAFE_F00D, 1'b0, 0, 16'd0);

    stall_cfg[0] = 2;
    issue("s0 stalled", 32'h0000_0010, HTRANS_NONSEQ, 0, 1, 32'h1111_0000, 1'b0, 2, 16'd0);
    stall_cfg[0] = 0;
    issue("s2 pipelined", 32'h2000_0000, HTRANS_NONSEQ, 2, 1, 32'h2222_0002, 1'b0, 0, 16'd0);

    HADDR = 32'h3000_0000;
    #1;
    chk("decode HSEL none", 32'(HSEL), 32'b000);
    issue("unmapped 1", 32'h3000_0000, HTRANS_NONSEQ, N, 1, 32'h0, 1'b1, 1, 16'd1);
    issue("unmapped idle", 32'h3000_0000, HTRANS_IDLE, N, 1, 32'h0, 1'b0, 0, 16'd1);
    issue("unmapped busy", 32'h3000_0004, HTRANS_BUSY, N, 1, 32'h0, 1'b0, 0, 16'd1);
    issue("unmapped 2", 32'h3000_0008, HTRANS_NONSEQ, N, 1, 32'h0, 1'b1, 1, 16'd2);
    issue("unmapped b2b", 32'h3000_000C, HTRANS_NONSEQ, N, 1, 32'h0, 1'b1, 1, 16'd3);

    resp_cfg[2] = 1'b1;
    issue("s2 error pass", 32'h2000_0004, HTRANS_SEQ, 2, 1, 32'h2222_0002, 1'b1, 0, 16'd3);
    issue("idle s0", 32'h0000_0000, HTRANS_IDLE, N, 1, 32'h1111_0000, 1'b0, 0, 16'd3);
    resp_cfg[2] = 1'b0;
    drain();

    // Reset while slave 1 is holding its data phase in wait states.
    stall_cfg[1] = 5;
    issue("s1 long stall", 32'h1000_0000, HTRANS_NONSEQ, 1, 0, 32'h0, 1'b0, 0, 16'd0);
    HTRANS = HTRANS_IDLE; bench_tgt = N;
    #2;
    chk("pre-reset HREADY", 32'(HREADY), 32'd0);
    HRESET = 1'b1;
    #1;
    chk("midreset HREADY", 32'(HREADY), 32'd1);
    chk("midreset HRESP", 32'(HRESP), 32'd0);
    chk("midreset HRDATA", HRDATA, 32'h0);
    chk("midreset ERR_CNT", 32'(ERR_CNT), 32'd0);
    repeat (2) @(posedge HCLK);
    #1;
    stall_cfg[1] = 0;
    HRESET = 1'b0;
    @(posedge HCLK);
    #1;
    issue("post-reset s0", 32'h0000_0020, HTRANS_NONSEQ, 0, 1, 32'h1111_0000, 1'b0, 0, 16'd0);
    issue("post-reset idle", 32'h3000_0000, HTRANS_IDLE, N, 0, 32'h0, 1'b0, 0, 16'd0);
    drain();

    HADDR2 = 32'h4000_0000;
    #1;
    chk("overlap HSEL", 32'(HSEL2), 32'b001);
    HADDR2 = 32'h3000_0000; HTRANS2 = HTRANS_NONSEQ;
    k = 0; b = 0;
    while (k < 5 && b < 40) begin
      @(negedge HCLK);
      if (HREADY2) begin
        @(posedge HCLK);
        k++;
      end else begin
        @(posedge HCLK);
      end
      b++;
    end
    #1;
    HTRANS2 = HTRANS_IDLE;
    chk("sat accepted", 32'(k), 32'd5);
    repeat (3) @(posedge HCLK);
    #1;
    chk("sat ERR_CNT", 32'(ERR_CNT2), 32'd3);
    chk("sat HREADY", 32'(HREADY2), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ahb_lite_interconnect.md
# ahb_lite_interconnect

Parametrised AHB-Lite single-master interconnect: decodes the address phase into one of `N_SLAVES` slave selects, registers that select into the data phase, and returns read data, response and ready from the selected slave. Unmapped non-idle transfers go to an internal default slave that gives the protocol-correct two-cycle ERROR response and bumps a saturating error counter. It sits between the master port and up to `N_SLAVES` memory-mapped peripherals.

## Interface
- `N_SLAVES`, 3: number of slave ports (1..16).
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `SLV_BASE`, `{N_SLAVES*ADDR_W}` zeros: packed base addresses; slave i is field i.
- `SLV_MASK`, `{N_SLAVES*ADDR_W}` zeros: packed masks; slave i hits when `(HADDR & mask_i) == base_i`.
- `ERRCNT_W`, 16: width of the error counter.

Ports:
- `HCLK` in 1: clock.
- `HRESET` in 1: reset, asynchronous, active-high.
- `HADDR` in ADDR_W: master address.
- `HTRANS` in 2: master transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- `HSEL` out N_SLAVES: one-hot address-phase slave select; combinational.
- `HRDATA_I` in N_SLAVES*DATA_W: packed slave read data; slave i is field i.
- `HRESP_I` in N_SLAVES: slave responses.
- `HREADYOUT_I` in N_SLAVES: slave ready outputs.
- `HRDATA` out DATA_W: read data to the master.
- `HRESP` out 1: response to the master and slaves (1 = ERROR).
- `HREADY` out 1: ready to the master, also fanned out to the slaves.
- `ERR_CNT` out ERRCNT_W: count of default-slave ERROR responses; saturates.

## Operation
- Address decode is combinational. `HSEL[i]` = hit_i AND no hit_j with j<i, so the lowest index wins on overlap. `HSEL` is asserted regardless of `HTRANS`.
- A transfer is active when `HTRANS[1]` is 1 (NONSEQ or SEQ).
- Data-phase select register `dsel`: either a slave index or DEFAULT. It loads only when `HREADY`=1.
  - Matched address: loads that slave index.
  - No match: loads DEFAULT.
- The default slave is a state machine with states DS_OKAY, DS_ERR1 and DS_ERR2.
  - When `HREADY`=1, no match and an active transfer, the next state is DS_ERR1. Otherwise, when `HREADY`=1, the next state is DS_OKAY.
  - DS_ERR1 always goes to DS_ERR2. DS_ERR2 obeys the `HREADY`=1 rule above, since `HREADY` is 1 in DS_ERR2.
  - Outputs per state: DS_OKAY gives ready=1, resp=0. DS_ERR1 gives ready=0, resp=1. DS_ERR2 gives ready=1, resp=1.
- Data-phase mux:
  - `dsel`=slave i: `HRDATA` = slice i of `HRDATA_I`, `HRESP` = `HRESP_I[i]`, `HREADY` = `HREADYOUT_I[i]`.
  - `dsel`=DEFAULT: `HRDATA` = 0, and `HRESP`/`HREADY` come from the default-slave state.
- `ERR_CNT` increments by 1 on each entry into DS_ERR1 and holds at all-ones.
- A selected slave's ERROR is passed through unchanged and is not counted.

## Timing
- Reset values: `dsel`=DEFAULT, default-slave state DS_OKAY, `ERR_CNT`=0. Resulting outputs: `HREADY`=1, `HRESP`=0, `HRDATA`=0. `HSEL` follows `HADDR` even during reset.
- Latency: the address phase in cycle n has its data phase from cycle n+1, lasting until that slave returns `HREADYOUT`=1.
- A wait-stated data phase (`HREADY`=0) holds `dsel`. The pipelined address presented during that phase is not captured until `HREADY`=1.
- A default ERROR always takes exactly 2 cycles. A back-to-back unmapped transfer issued during DS_ERR2 goes to DS_ERR1 in the next cycle.
- Reset asserted mid-transfer returns to the reset values immediately and asynchronously.

## Structure
- Shared package `ahb_pkg`:
  - HTRANS encodings `HTRANS_IDLE`, `HTRANS_BUSY`, `HTRANS_NONSEQ`, `HTRANS_SEQ`.
  - `HRESP_OKAY`, `HRESP_ERROR`.
  - Default-slave state enum `ds_state_t`.
- One sub-module, `ahb_default_slave`. Inputs: `HCLK`, `HRESET`, `HREADY`, a start strobe. Outputs: ready, resp, error-count increment. The top level holds the decoder, the `dsel` register, the mux and `ERR_CNT`.
- `dsel` width is `$clog2(N_SLAVES+1)`; DEFAULT is encoded as `N_SLAVES`.

## Test plan
- Reset: drive `HRESET`=1 mid-transfer with slave 1 stalled. Required: `HREADY`=1, `HRESP`=0, `HRDATA`=0, `ERR_CNT`=0 while reset is held.
- Decode and mux: N=3, bases 0x0000_0000, 0x1000_0000, 0x2000_0000, masks 0xF000_0000. NONSEQ to 0x1000_0040 with slave 1 returning 0xCAFEF00D. Required: `HSEL`=3'b010, and the next cycle `HRDATA`=0xCAFEF00D.
- Wait states with pipelined address: slave 0 has `HREADYOUT`=0 for 2 cycles while the next NONSEQ targets slave 2. Required: `HRDATA` stays from slave 0 until ready, then the data phase switches to slave 2.
- Unmapped error: NONSEQ to 0x3000_0000. Required: the next cycle is `HREADY`=0, `HRESP`=1; the cycle after is `HREADY`=1, `HRESP`=1; `ERR_CNT`=1.
- Unmapped IDLE and BUSY: IDLE to 0x3000_0000. Required: OKAY with zero wait and no change to `ERR_CNT`.
- Overlap and saturation: overlapping maps with slaves 0 and 2 both hitting give `HSEL`=3'b001. With ERRCNT_W=2, 5 back-to-back unmapped transfers give `ERR_CNT`=3.
